// File: rtl/mem_access_stage.sv
// RV32IM memory stage: drives the data bus, extracts load data and
// owns the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_op2_selected,
    input  logic        mem_memory_write,
    input  logic [2:0]  mem_memory_load_type,
    input  logic [1:0]  mem_memory_store_type,
    input  logic        mem_wb_load,
    input  logic        mem_wb_reg_file,
    input  logic [4:0]  mem_wb_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] wb_result,
    output logic        wb_reg_file,
    output logic [4:0]  wb_rd,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [8:0] LIMIT = 9'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [8:0]  cnt_inc;
    logic        st_act;
    logic        ld_act;
    logic        active;
    logic [1:0]  size;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        go;
    logic        abort;
    logic [1:0]  a;
    logic [3:0]  be_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign a       = mem_result[1:0];
    assign st_act  = mem_memory_write & (mem_memory_store_type != 2'b11);
    assign ld_act  = mem_wb_load & (mem_memory_load_type != 3'b111);
    assign active  = st_act | ld_act;
    assign size    = st_act ? mem_memory_store_type
                            : mem_memory_load_type[1:0];
    assign is_byte = (size == 2'b00);
    assign is_half = (size == 2'b01);
    assign is_word = size[1];

    assign misaligned = active & ((is_half & a[0]) | (is_word & (|a)));
    assign go         = active & ~misaligned;

    // Abort when the incremented wait count would reach TIMEOUT-1.
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign abort   = (state == WAIT) & ~dmem_ready & (cnt_inc >= LIMIT);

    always_comb begin
        dmem_req = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE:    dmem_req = go;
                WAIT:    dmem_req = ~abort;
                default: dmem_req = 1'b0;
            endcase
        end
    end

    assign mem_stall = dmem_req & ~dmem_ready & ~abort;
    assign dmem_we   = dmem_req & st_act;
    assign dmem_addr = {mem_result[31:2], 2'b00};

    always_comb begin
        be_raw     = 4'b1111;
        dmem_wdata = mem_op2_selected;
        unique case (1'b1)
            is_byte: begin
                be_raw     = 4'b0001 << a;
                dmem_wdata = {4{mem_op2_selected[7:0]}};
            end
            is_half: begin
                be_raw     = 4'b0011 << a;
                dmem_wdata = {2{mem_op2_selected[15:0]}};
            end
            default: begin
                be_raw     = 4'b1111;
                dmem_wdata = mem_op2_selected;
            end
        endcase
    end

    assign dmem_be = dmem_we ? be_raw : 4'b0000;

    assign ld_byte = 8'(dmem_rdata >> {a, 3'b000});
    assign ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_data = dmem_rdata;
        unique case (mem_memory_load_type)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            wb_result    <= 32'd0;
            wb_reg_file  <= 1'b0;
            wb_rd        <= 5'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go && !dmem_ready) begin
                        state <= WAIT;
                        cnt   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (dmem_ready || abort) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc[7:0];
                    end
                end
                default: state <= IDLE;
            endcase

            misalign_err <= misaligned;
            bus_err      <= abort;

            if (mem_stall) begin
                wb_reg_file <= 1'b0;
            end else begin
                wb_result   <= mem_wb_load ? ld_data : mem_result;
                wb_reg_file <= mem_wb_reg_file & ~misaligned
                               & ~abort & ~st_act;
                wb_rd       <= mem_wb_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: driver pushes expected write-backs,
// a monitor pops and compares them as the stage retires each instruction.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_result = '0;
    logic [31:0] mem_op2_selected = '0;
    logic        mem_memory_write = 1'b0;
    logic [2:0]  mem_memory_load_type = 3'b111;
    logic [1:0]  mem_memory_store_type = 2'b11;
    logic        mem_wb_load = 1'b0;
    logic        mem_wb_reg_file = 1'b0;
    logic [4:0]  mem_wb_rd = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic        wb_reg_file;
    logic [4:0]  wb_rd;
    logic        misalign_err;
    logic        bus_err;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .mem_result(mem_result),
        .mem_op2_selected(mem_op2_selected),
        .mem_memory_write(mem_memory_write),
        .mem_memory_load_type(mem_memory_load_type),
        .mem_memory_store_type(mem_memory_store_type),
        .mem_wb_load(mem_wb_load),
        .mem_wb_reg_file(mem_wb_reg_file),
        .mem_wb_rd(mem_wb_rd),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be),
        .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .wb_result(wb_result),
        .wb_reg_file(wb_reg_file),
        .wb_rd(wb_rd),
        .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rf;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: stalled edges must be bubbles, others retire one entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst || done) continue;
            if (mem_stall) begin
                @(posedge clk);
                #1;
                chk("bubble_rf", {31'd0, wb_reg_file}, 32'd0);
            end else begin
                exp_t e;
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_reg_file", {31'd0, wb_reg_file}, {31'd0, e.rf});
                    chk("wb_result", wb_result, e.res);
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("misalign_err", {31'd0, misalign_err},
                        {31'd0, e.mis});
                    chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                end
            end
        end
    end

    task automatic drive(input logic [2:0] lt, input logic [1:0] st,
                         input logic wr, input logic ld, input logic rf,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] op2, input logic [31:0] rdata);
        mem_memory_load_type  = lt;
        mem_memory_store_type = st;
        mem_memory_write      = wr;
        mem_wb_load           = ld;
        mem_wb_reg_file       = rf;
        mem_wb_rd             = rd;
        mem_result            = res;
        mem_op2_selected      = op2;
        dmem_rdata            = rdata;
    endtask

    task automatic issue(input logic [2:0] lt, input logic [1:0] st,
                         input logic wr, input logic ld,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] op2, input logic [31:0] rdata,
                         input int dly, input exp_t e, input int estall,
                         input bit ereq, input bit ewe,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input bit tmo);
        int k;
        bit first;
        sb.push_back(e);
        drive(lt, st, wr, ld, 1'b1, rd, res, op2, rdata);
        k = 0;
        first = 1'b1;
        dmem_ready = (dly == 0);
        for (int guard = 0; guard < 64; guard++) begin
            @(negedge clk);
            if (first || mem_stall) begin
                chk("dmem_req", {31'd0, dmem_req}, {31'd0, ereq});
                if (ereq) begin
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, ewe});
                    chk("dmem_addr", dmem_addr, {res[31:2], 2'b00});
                    chk("dmem_be", {28'd0, dmem_be}, {28'd0, ebe});
                    if (ewe) chk("dmem_wdata", dmem_wdata, ewd);
                end
            end else if (tmo) begin
                chk("abort_req", {31'd0, dmem_req}, 32'd0);
            end
            first = 1'b0;
            if (!mem_stall) break;
            if (k >= 40) begin
                chk("stall_bound", 32'd1, 32'd0);
                break;
            end
            @(posedge clk);
            #2;
            k++;
            dmem_ready = (k == dly);
        end
        chk("stall_cycles", k, estall);
        @(posedge clk);
        #2;
        dmem_ready = 1'b0;
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd);
        issue(3'b111, 2'b11, 1'b0, 1'b0, rd, res, 32'h0, 32'h0, 0,
              '{1'b1, res, rd, 1'b0, 1'b0}, 0, 1'b0, 1'b0, 4'h0, 32'h0,
              1'b0);
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [31:0] addr,
                           input logic [31:0] rdata, input int dly,
                           input logic [4:0] rd, input logic [31:0] eres,
                           input bit emis, input bit eberr,
                           input int estall);
        issue(lt, 2'b11, 1'b0, 1'b1, rd, addr, 32'h0, rdata, dly,
              '{!emis && !eberr, eres, rd, emis, eberr}, estall, !emis,
              1'b0, 4'h0, 32'h0, eberr);
    endtask

    task automatic do_store(input logic [1:0] st, input logic [31:0] addr,
                            input logic [31:0] op2, input int dly,
                            input logic [4:0] rd, input logic [3:0] ebe,
                            input logic [31:0] ewd, input bit emis,
                            input int estall);
        issue(3'b111, st, 1'b1, 1'b0, rd, addr, op2, 32'h0, dly,
              '{1'b0, addr, rd, emis, 1'b0}, estall, !emis, 1'b1, ebe,
              ewd, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_wb_rf", {31'd0, wb_reg_file}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        do_alu(32'h1234_5678, 5'd5);
        do_load(3'b100, 32'h001, 32'h0000_9900, 0, 5'd6, 32'h99,
                1'b0, 1'b0, 0);
        do_load(3'b000, 32'h103, 32'h80FF_1234, 0, 5'd7, 32'hFFFF_FF80,
                1'b0, 1'b0, 0);
        do_store(2'b01, 32'h202, 32'h0000_ABCD, 3, 5'd8, 4'b1100,
                 32'hABCD_ABCD, 1'b0, 3);
        do_load(3'b010, 32'h006, 32'h1122_3344, 0, 5'd9, 32'h1122_3344,
                1'b1, 1'b0, 0);
        do_load(3'b101, 32'h010, 32'h0, 255, 5'd10, 32'h0,
                1'b0, 1'b1, 15);
        do_load(3'b001, 32'h012, 32'h8001_7FFF, 1, 5'd11, 32'hFFFF_8001,
                1'b0, 1'b0, 1);
        do_store(2'b00, 32'h003, 32'h0000_00A5, 0, 5'd12, 4'b1000,
                 32'hA5A5_A5A5, 1'b0, 0);
        do_store(2'b10, 32'h104, 32'hDEAD_BEEF, 2, 5'd13, 4'b1111,
                 32'hDEAD_BEEF, 1'b0, 2);
        do_load(3'b101, 32'h002, 32'hBEEF_0000, 0, 5'd14, 32'h0000_BEEF,
                1'b0, 1'b0, 0);
        do_store(2'b10, 32'h101, 32'h0000_0001, 0, 5'd15, 4'b1111,
                 32'h0000_0001, 1'b1, 0);
        do_load(3'b010, 32'h008, 32'hCAFE_F00D, 0, 5'd16, 32'hCAFE_F00D,
                1'b0, 1'b0, 0);
        do_alu(32'hFFFF_FFFF, 5'd31);

        // Store that never completes, interrupted by reset mid-wait.
        drive(3'b111, 2'b10, 1'b1, 1'b0, 1'b1, 5'd4, 32'h20,
              32'h0000_0055, 32'h0);
        @(negedge clk);
        chk("rw_req_first", {31'd0, dmem_req}, 32'd1);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rw_req_wait", {31'd0, dmem_req}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rw_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rw_stall", {31'd0, mem_stall}, 32'd0);
        chk("rw_wb_result", wb_result, 32'd0);
        chk("rw_wb_rf", {31'd0, wb_reg_file}, 32'd0);
        chk("rw_wb_rd", {27'd0, wb_rd}, 32'd0);
        drive(3'b111, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        do_load(3'b010, 32'h020, 32'h0000_0005, 0, 5'd3, 32'h5,
                1'b0, 1'b0, 0);

        done = 1'b1;
        drive(3'b111, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
